mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator for the memory responder's write, read and permission ports.
- Accepts one load, store or set-permission command at a time from the CPU datapath and holds the matching req level until ack.
- Returns one response pulse with read data or an error flag.
- Sits between the core pipeline and the memory top; no outstanding-request overlap.

Parameters:
ADDR_WIDTH, 16, address bits on all ports
DATA_WIDTH, 16, data bits on all ports
TIMEOUT_CYCLES, 15, wait-state cycles without ack before a command is aborted (must be >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  00 LOAD, 01 STORE, 10 SETPERM, 11 reserved
cmd_addr  in  ADDR_WIDTH  access address / permission start
cmd_addr_end  in  ADDR_WIDTH  permission end (SETPERM only)
cmd_wdata  in  DATA_WIDTH  store data
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_data  out  DATA_WIDTH  load data, 0 otherwise
rsp_err  out  1  error qualifier for rsp_valid
wr_req  out  1  write request level
wr_addr  out  ADDR_WIDTH  write address
wr_data  out  DATA_WIDTH  write data
wr_ack  in  1  write acknowledge
perm_err  in  1  write-protect error, valid with wr_ack
rd_req  out  1  read request level
rd_addr  out  ADDR_WIDTH  read address
rd_data  in  DATA_WIDTH  read data, valid with rd_ack
rd_ack  in  1  read acknowledge
perm_req  out  1  one-cycle permission update pulse
perm_addr_start  out  ADDR_WIDTH  protected range start
perm_addr_end  out  ADDR_WIDTH  protected range end

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset mid-operation drops req immediately; no response is issued for the aborted command.
- cmd_ready = (state==IDLE) && !rd_ack && !wr_ack. This rule ensures a new req is never raised while a stale ack from the prior access is still high.
- States: IDLE, RD_WAIT, WR_WAIT, PERM, RESP.
- IDLE, on accept:
  - LOAD -> RD_WAIT; rd_req=1 and rd_addr registered.
  - STORE -> WR_WAIT; wr_req=1 and wr_addr/wr_data registered.
  - SETPERM with addr<=addr_end -> PERM; perm_req=1 and range registered.
  - SETPERM with addr>addr_end, or reserved op -> RESP with rsp_err=1; no memory activity.
- RD_WAIT, on rd_ack sampled 1:
  - rd_req<=0, rsp_data<=rd_data, rsp_err<=0, rsp_valid<=1 -> RESP.
- WR_WAIT, on wr_ack sampled 1:
  - wr_req<=0, rsp_err<=perm_err, rsp_data<=0, rsp_valid<=1 -> RESP.
- PERM: perm_req high exactly one cycle; then rsp_valid=1, rsp_err=0 -> RESP.
- RESP: rsp_valid high exactly one cycle, then -> IDLE. rsp_data/rsp_err hold until the next response.
- Timeout: counter clears on entry to a WAIT state and increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES, req drops, rsp_valid=1, rsp_err=1, rsp_data=0 -> RESP. A late ack is absorbed by the cmd_ready gating.
- Latency against a responder that acks one cycle after req:
  - LOAD/STORE accepted at T0: req high T1-T2; rsp_valid T3; cmd_ready high again T4 or T5 (after ack falls).
  - SETPERM accepted at T0: perm_req T1; rsp_valid T2.
- Outputs wr_addr/wr_data/rd_addr are stable for the whole req interval.

Optional Feature:
MEM_ACCESS_TIMEOUT_EN:
- Defined: timeout counter and abort path present as described.
- Undefined: no counter; WAIT states hold req indefinitely until ack; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package mem_access_pkg holds:
  - cmd_op enum (OP_LOAD, OP_STORE, OP_SETPERM, OP_RSVD)
  - FSM state enum
  - default TIMEOUT_CYCLES constant
- No sub-module is needed; the timeout counter stays inline under the macro.

Test Plan:
- Program responder mem[0x0010]=0xBEEF; LOAD 0x0010 -> rsp_valid at T3, rsp_data=0xBEEF, rsp_err=0, rd_req high exactly 2 cycles.
- STORE 0x0020 data 0x1234 (unprotected), then LOAD 0x0020 -> first rsp_err=0; second rsp_data=0x1234.
- SETPERM 0x0040..0x004F, then STORE 0x0045 -> perm_req 1-cycle pulse with start=0x0040/end=0x004F; store rsp_err=1; LOAD 0x0045 returns old value.
- SETPERM start=0x0050 end=0x0040, and a separately issued reserved op 11 -> each gives rsp_valid with rsp_err=1; perm_req/wr_req/rd_req never assert.
- Timeout (macro on): responder ack tied 0, LOAD -> rd_req high 15 cycles, then rsp_err=1, rsp_data=0; a late ack pulse holds cmd_ready low.
- Assert rst during RD_WAIT -> rd_req=0 same cycle asynchronously; no rsp_valid; next LOAD completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: command opcodes, FSM states and default timeout for mem_access_ctrl.
package mem_access_pkg;
  typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_SETPERM, OP_RSVD} cmd_op_e;
  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, PERM, RESP} state_e;
  localparam int TIMEOUT_CYCLES_DEF = 15;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store/set-permission initiator toward the memory responder.
// Define MEM_ACCESS_TIMEOUT_EN to abort wait states that see no ack within TIMEOUT_CYCLES.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_end,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ack,
  input  logic                  perm_err,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ack,
  output logic                  perm_req,
  output logic [ADDR_WIDTH-1:0] perm_addr_start,
  output logic [ADDR_WIDTH-1:0] perm_addr_end
);
  state_e state, state_n;
  cmd_op_e op;
  logic accept, timeout;
  logic rsp_valid_n, rsp_err_n, wr_req_n, rd_req_n, perm_req_n;
  logic [DATA_WIDTH-1:0] rsp_data_n, wr_data_n;
  logic [ADDR_WIDTH-1:0] wr_addr_n, rd_addr_n, perm_addr_start_n, perm_addr_end_n;
  assign op = cmd_op_e'(cmd_op);
  // a lingering ack from the previous access must fall before a new req may rise
  assign cmd_ready = !rst && state == IDLE && !rd_ack && !wr_ack;
  assign accept = cmd_valid && cmd_ready;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= ((state == RD_WAIT && !rd_ack) || (state == WR_WAIT && !wr_ack)) ? cnt + 1'b1 : '0;
`else
  // parameter is ignored in this build; the comparison is false for any legal value
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_comb begin
    state_n = state;
    rsp_valid_n = 1'b0;
    rsp_err_n = rsp_err;
    rsp_data_n = rsp_data;
    wr_req_n = wr_req;
    rd_req_n = rd_req;
    perm_req_n = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    rd_addr_n = rd_addr;
    perm_addr_start_n = perm_addr_start;
    perm_addr_end_n = perm_addr_end;
    case (state)
      IDLE: if (accept) begin
        if (op == OP_LOAD) begin
          state_n = RD_WAIT;
          rd_req_n = 1'b1;
          rd_addr_n = cmd_addr;
        end else if (op == OP_STORE) begin
          state_n = WR_WAIT;
          wr_req_n = 1'b1;
          wr_addr_n = cmd_addr;
          wr_data_n = cmd_wdata;
        end else if (op == OP_SETPERM && cmd_addr <= cmd_addr_end) begin
          state_n = PERM;
          perm_req_n = 1'b1;
          perm_addr_start_n = cmd_addr;
          perm_addr_end_n = cmd_addr_end;
        end else begin
          state_n = RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n = 1'b1;
          rsp_data_n = '0;
        end
      end
      RD_WAIT: if (rd_ack || timeout) begin
        state_n = RESP;
        rd_req_n = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_err_n = !rd_ack;
        rsp_data_n = rd_ack ? rd_data : '0;
      end
      WR_WAIT: if (wr_ack || timeout) begin
        state_n = RESP;
        wr_req_n = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_err_n = !wr_ack || perm_err;
        rsp_data_n = '0;
      end
      PERM: begin
        state_n = RESP;
        rsp_valid_n = 1'b1;
        rsp_err_n = 1'b0;
        rsp_data_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
      wr_req <= 1'b0;
      rd_req <= 1'b0;
      perm_req <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_addr <= '0;
      perm_addr_start <= '0;
      perm_addr_end <= '0;
    end else begin
      state <= state_n;
      rsp_valid <= rsp_valid_n;
      rsp_err <= rsp_err_n;
      rsp_data <= rsp_data_n;
      wr_req <= wr_req_n;
      rd_req <= rd_req_n;
      perm_req <= perm_req_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      rd_addr <= rd_addr_n;
      perm_addr_start <= perm_addr_start_n;
      perm_addr_end <= perm_addr_end_n;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random command checks against a command-level reference model.
module tb_mem_access_ctrl;
  localparam int TO = 15;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [15:0] cmd_addr = 0, cmd_addr_end = 0, cmd_wdata = 0;
  logic rsp_valid, rsp_err, wr_req, wr_ack, rd_req, rd_ack, perm_req;
  logic [15:0] rsp_data, wr_addr, wr_data, rd_addr, perm_addr_start, perm_addr_end;
  logic perm_err, rd_ack_q, wr_ack_q;
  logic [15:0] rd_data;
  logic late_rd_ack = 0, ack_en = 1, pre_we = 0;
  logic [7:0] pre_a = 0;
  logic [15:0] pre_d = 0;
  int tests = 0, fails = 0;

  mem_access_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_addr_end(cmd_addr_end), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .perm_err(perm_err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .perm_req(perm_req), .perm_addr_start(perm_addr_start), .perm_addr_end(perm_addr_end));

  // responder: acks one cycle after req, one protected range replaced by each perm_req
  bit [15:0] rmem [256];
  bit r_v;
  bit [15:0] r_lo, r_hi;
  assign rd_ack = rd_ack_q | late_rd_ack;
  assign wr_ack = wr_ack_q;
  always @(posedge clk or posedge rst)
    if (rst) begin
      rd_ack_q <= 0; wr_ack_q <= 0; perm_err <= 0; rd_data <= 0;
    end else begin
      rd_ack_q <= ack_en && rd_req && !rd_ack_q;
      wr_ack_q <= ack_en && wr_req && !wr_ack_q;
      if (rd_req && !rd_ack_q) rd_data <= rmem[rd_addr[7:0]];
      if (wr_req && !wr_ack_q) begin
        perm_err <= r_v && wr_addr >= r_lo && wr_addr <= r_hi;
        if (ack_en && !(r_v && wr_addr >= r_lo && wr_addr <= r_hi)) rmem[wr_addr[7:0]] <= wr_data;
      end
      if (perm_req) begin r_v <= 1; r_lo <= perm_addr_start; r_hi <= perm_addr_end; end
      if (pre_we) rmem[pre_a] <= pre_d;
    end

  // reference model: architectural memory and protected range, updated per command
  bit [15:0] ref_mem [256];
  bit ref_v;
  bit [15:0] ref_lo, ref_hi;
  logic [15:0] x_data;
  logic x_err;
  int x_lat, x_rd, x_wr, x_pm;
  function automatic void ref_exec(input logic [1:0] op, input logic [15:0] a, e, d);
    x_data = 0; x_err = 0; x_rd = 0; x_wr = 0; x_pm = 0; x_lat = 1;
    case (op)
      2'b00: begin x_data = ref_mem[a[7:0]]; x_lat = 3; x_rd = 2; end
      2'b01: begin
        x_err = ref_v && a >= ref_lo && a <= ref_hi;
        if (!x_err) ref_mem[a[7:0]] = d;
        x_lat = 3; x_wr = 2;
      end
      2'b10: if (a <= e) begin ref_v = 1; ref_lo = a; ref_hi = e; x_lat = 2; x_pm = 1; end
             else x_err = 1;
      default: x_err = 1;
    endcase
  endfunction

  logic [15:0] o_data, p_lo, p_hi;
  logic o_err, stable, a_valid, a_ready, a_hold;
  int lat, rd_n, wr_n, pm_n;

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk); pre_we = 1; pre_a = a; pre_d = d; ref_mem[a] = d;
    @(negedge clk); pre_we = 0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, e, d);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_addr_end = e; cmd_wdata = d;
    @(posedge clk); #1 cmd_valid = 0;
    lat = -1; rd_n = 0; wr_n = 0; pm_n = 0; stable = 1; p_lo = 0; p_hi = 0; o_data = 0; o_err = 0;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (rd_req) begin rd_n++; if (rd_addr !== a) stable = 0; end
      if (wr_req) begin wr_n++; if (wr_addr !== a || wr_data !== d) stable = 0; end
      if (perm_req) begin pm_n++; p_lo = perm_addr_start; p_hi = perm_addr_end; end
      if (rsp_valid) begin lat = k; o_data = rsp_data; o_err = rsp_err; end
    end
    if (lat > 0) begin
      @(negedge clk);
      a_valid = rsp_valid; a_ready = cmd_ready; a_hold = rsp_data === o_data && rsp_err === o_err;
    end else begin
      a_valid = 1; a_ready = 0; a_hold = 0;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1;
    #3;
    tests++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, wr_req, wr_addr, wr_data, rd_req, rd_addr,
         perm_req, perm_addr_start, perm_addr_end} !== '0) begin
      fails++; $display("FAIL reset_outputs got nonzero outputs ready=%b rsp_v=%b rd_req=%b wr_req=%b exp all 0",
                        cmd_ready, rsp_valid, rd_req, wr_req);
    end
    @(negedge clk); rst = 0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_load;
    preload(8'h10, 16'hBEEF);
    ref_exec(2'b00, 16'h0010, 0, 0);
    run_cmd(2'b00, 16'h0010, 0, 0);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL load_latency got %0d exp 3", lat); end
    tests++;
    if ({o_err, o_data} !== {1'b0, 16'hBEEF}) begin fails++; $display("FAIL load_data got err=%b data=%h exp err=0 data=beef", o_err, o_data); end
    tests++;
    if (rd_n !== 2 || wr_n !== 0 || pm_n !== 0 || !stable) begin
      fails++; $display("FAIL load_req got rd=%0d wr=%0d pm=%0d stable=%b exp rd=2 wr=0 pm=0 stable=1", rd_n, wr_n, pm_n, stable);
    end
    tests++;
    if (a_valid !== 0 || a_ready !== 1 || !a_hold) begin
      fails++; $display("FAIL load_after got valid=%b ready=%b hold=%b exp 0 1 1", a_valid, a_ready, a_hold);
    end
  endtask

  task automatic test_store_load;
    ref_exec(2'b01, 16'h0020, 0, 16'h1234);
    run_cmd(2'b01, 16'h0020, 0, 16'h1234);
    tests++;
    if (lat !== 3 || o_err !== 0 || wr_n !== 2 || !stable) begin
      fails++; $display("FAIL store_ok got lat=%0d err=%b wr=%0d stable=%b exp 3 0 2 1", lat, o_err, wr_n, stable);
    end
    ref_exec(2'b00, 16'h0020, 0, 0);
    run_cmd(2'b00, 16'h0020, 0, 0);
    tests++;
    if (o_data !== x_data || o_err !== 0) begin fails++; $display("FAIL store_readback got %h exp %h", o_data, x_data); end
  endtask

  task automatic test_setperm;
    preload(8'h45, 16'h5555);
    ref_exec(2'b10, 16'h0040, 16'h004F, 0);
    run_cmd(2'b10, 16'h0040, 16'h004F, 0);
    tests++;
    if (lat !== 2 || pm_n !== 1 || p_lo !== 16'h0040 || p_hi !== 16'h004F || o_err !== 0) begin
      fails++; $display("FAIL setperm got lat=%0d pm=%0d lo=%h hi=%h err=%b exp 2 1 0040 004f 0", lat, pm_n, p_lo, p_hi, o_err);
    end
    ref_exec(2'b01, 16'h0045, 0, 16'hAAAA);
    run_cmd(2'b01, 16'h0045, 0, 16'hAAAA);
    tests++;
    if (o_err !== 1'b1 || lat !== 3) begin fails++; $display("FAIL protected_store got err=%b lat=%0d exp 1 3", o_err, lat); end
    ref_exec(2'b00, 16'h0045, 0, 0);
    run_cmd(2'b00, 16'h0045, 0, 0);
    tests++;
    if (o_data !== 16'h5555) begin fails++; $display("FAIL protected_keep got %h exp 5555", o_data); end
  endtask

  task automatic test_errors;
    run_cmd(2'b10, 16'h0050, 16'h0040, 0);
    tests++;
    if (lat !== 1 || o_err !== 1 || o_data !== 0 || rd_n + wr_n + pm_n !== 0) begin
      fails++; $display("FAIL bad_range got lat=%0d err=%b data=%h reqs=%0d exp 1 1 0000 0", lat, o_err, o_data, rd_n + wr_n + pm_n);
    end
    run_cmd(2'b11, 16'h0010, 16'h0020, 16'h7777);
    tests++;
    if (lat !== 1 || o_err !== 1 || o_data !== 0 || rd_n + wr_n + pm_n !== 0) begin
      fails++; $display("FAIL reserved_op got lat=%0d err=%b data=%h reqs=%0d exp 1 1 0000 0", lat, o_err, o_data, rd_n + wr_n + pm_n);
    end
  endtask

  task automatic test_timeout;
`ifdef MEM_ACCESS_TIMEOUT_EN
    ack_en = 0;
    run_cmd(2'b00, 16'h0010, 0, 0);
    tests++;
    if (lat !== TO + 1 || rd_n !== TO || o_err !== 1 || o_data !== 0) begin
      fails++; $display("FAIL load_timeout got lat=%0d rd=%0d err=%b data=%h exp %0d %0d 1 0000", lat, rd_n, o_err, o_data, TO + 1, TO);
    end
    run_cmd(2'b01, 16'h0030, 0, 16'h9999);
    tests++;
    if (lat !== TO + 1 || wr_n !== TO || o_err !== 1) begin
      fails++; $display("FAIL store_timeout got lat=%0d wr=%0d err=%b exp %0d %0d 1", lat, wr_n, o_err, TO + 1, TO);
    end
    @(negedge clk); late_rd_ack = 1; #1;
    tests++;
    if (cmd_ready !== 0) begin fails++; $display("FAIL late_ack_gate got ready=%b exp 0", cmd_ready); end
    @(negedge clk); late_rd_ack = 0; #1;
    tests++;
    if (cmd_ready !== 1) begin fails++; $display("FAIL late_ack_release got ready=%b exp 1", cmd_ready); end
    ack_en = 1;
`else
    int seen = 0;
    ack_en = 0;
    run_cmd(2'b00, 16'h0010, 0, 0);
    tests++;
    if (lat !== -1 || rd_n !== 60) begin fails++; $display("FAIL hold_req got lat=%0d rd=%0d exp -1 60", lat, rd_n); end
    ack_en = 1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; o_data = rsp_data; o_err = rsp_err; end
    end
    tests++;
    if (!seen || o_data !== 16'hBEEF || o_err !== 0) begin
      fails++; $display("FAIL held_load got seen=%0d data=%h err=%b exp 1 beef 0", seen, o_data, o_err);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int nv = 0;
    @(negedge clk); while (!cmd_ready) @(negedge clk);
    cmd_valid = 1; cmd_op = 2'b00; cmd_addr = 16'h0010;
    @(posedge clk); #1 cmd_valid = 0;
    @(negedge clk); #1 rst = 1; #1;
    tests++;
    if (rd_req !== 0) begin fails++; $display("FAIL async_reset_req got %b exp 0", rd_req); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); if (rsp_valid) nv++;
      if (k == 1) rst = 0;
    end
    tests++;
    if (nv !== 0) begin fails++; $display("FAIL reset_no_rsp got %0d pulses exp 0", nv); end
    ref_exec(2'b00, 16'h0010, 0, 0);
    run_cmd(2'b00, 16'h0010, 0, 0);
    tests++;
    if (lat !== 3 || o_data !== x_data || o_err !== 0) begin
      fails++; $display("FAIL post_reset_load got lat=%0d data=%h err=%b exp 3 %h 0", lat, o_data, o_err, x_data);
    end
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [15:0] a, e, d;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = r < 4 ? 2'b00 : r < 7 ? 2'b01 : r < 9 ? 2'b10 : 2'b11;
      a = 16'($urandom_range(0, 255));
      d = 16'($urandom);
      e = ($urandom_range(0, 3) == 0 && a > 0) ? a - 16'($urandom_range(1, a)) : a + 16'($urandom_range(0, 8));
      ref_exec(op, a, e, d);
      run_cmd(op, a, e, d);
      tests++;
      if ({o_err, o_data} !== {x_err, x_data}) begin
        fails++; $display("FAIL rnd_rsp[%0d] op=%0d addr=%h got err=%b data=%h exp err=%b data=%h", i, op, a, o_err, o_data, x_err, x_data);
      end
      tests++;
      if (lat !== x_lat || rd_n !== x_rd || wr_n !== x_wr || pm_n !== x_pm || (x_pm == 1 && {p_lo, p_hi} !== {a, e})) begin
        fails++; $display("FAIL rnd_timing[%0d] op=%0d got lat=%0d rd=%0d wr=%0d pm=%0d exp %0d %0d %0d %0d", i, op, lat, rd_n, wr_n, pm_n, x_lat, x_rd, x_wr, x_pm);
      end
      tests++;
      if (!stable || a_valid !== 0 || a_ready !== 1 || !a_hold) begin
        fails++; $display("FAIL rnd_protocol[%0d] got stable=%b valid=%b ready=%b hold=%b exp 1 0 1 1", i, stable, a_valid, a_ready, a_hold);
      end
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_store_load;
    test_setperm;
    test_errors;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
